// File: rtl/sub_seq_pkg.sv
// Shared types and constants for the add/subtract operand sequencer.
package sub_seq_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_B,
        EXEC,
        DONE
    } seq_state_e;

endpackage

// File: rtl/sub_result_reg.sv
// Result/flag capture registers with the res_valid/res_ack handshake.
// Optional res_ovf port exists only when SIGNED_OVF_EN is defined.
module sub_result_reg
    import sub_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic             ack,
    input  logic [WIDTH-1:0] dp_sum,
    input  logic             dp_cout,
    input  logic             dp_zero,
    input  logic             dp_leq,
`ifdef SIGNED_OVF_EN
    input  logic             ovf,
    output logic             res_ovf,
`endif
    output logic [WIDTH-1:0] res,
    output logic             res_cout,
    output logic             res_zero,
    output logic             res_leq,
    output logic             res_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res       <= '0;
            res_cout  <= 1'b0;
            res_zero  <= 1'b0;
            res_leq   <= 1'b0;
            res_valid <= 1'b0;
`ifdef SIGNED_OVF_EN
            res_ovf   <= 1'b0;
`endif
        end else if (capture) begin
            res       <= dp_sum;
            res_cout  <= dp_cout;
            res_zero  <= dp_zero;
            res_leq   <= dp_leq;
            res_valid <= 1'b1;
`ifdef SIGNED_OVF_EN
            res_ovf   <= ovf;
`endif
        end else if (ack && res_valid) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sub_operand_seq.sv
// Operand sequencer for the 8-bit add/subtract datapath: collects A then B,
// holds them for EXEC_LAT cycles, captures the result. Macro: SIGNED_OVF_EN.
module sub_operand_seq
    import sub_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned EXEC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             mode,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_mod,
    output logic             op_cin,
    input  logic [WIDTH-1:0] dp_sum,
    input  logic             dp_cout,
    input  logic             dp_zero,
    input  logic             dp_leq,
    output logic [WIDTH-1:0] res,
    output logic             res_cout,
    output logic             res_zero,
    output logic             res_leq,
`ifdef SIGNED_OVF_EN
    output logic             res_ovf,
`endif
    output logic             res_valid,
    input  logic             res_ack
);

    localparam int unsigned CW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_LAT - 1);

    seq_state_e    state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          capture;

    assign accept  = din_valid && din_ready;
    assign capture = (state == EXEC) && (cnt == CNT_LAST);

    // din_ready is registered, so it is computed from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            din_ready <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_mod    <= 1'b0;
            op_cin    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    din_ready <= 1'b1;
                    if (accept) begin
                        op_a   <= din;
                        op_mod <= mode;
                        op_cin <= mode;
                        state  <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        op_b      <= din;
                        din_ready <= 1'b0;
                        cnt       <= '0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (res_ack && res_valid) begin
                        din_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    din_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef SIGNED_OVF_EN
    logic ovf;
    assign ovf = (op_a[WIDTH-1] == (op_b[WIDTH-1] ^ op_mod)) &&
                 (dp_sum[WIDTH-1] != op_a[WIDTH-1]);
`endif

    sub_result_reg #(
        .WIDTH(WIDTH)
    ) u_result (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .ack      (res_ack),
        .dp_sum   (dp_sum),
        .dp_cout  (dp_cout),
        .dp_zero  (dp_zero),
        .dp_leq   (dp_leq),
`ifdef SIGNED_OVF_EN
        .ovf      (ovf),
        .res_ovf  (res_ovf),
`endif
        .res      (res),
        .res_cout (res_cout),
        .res_zero (res_zero),
        .res_leq  (res_leq),
        .res_valid(res_valid)
    );

endmodule
